// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Loader FSM encodings and header/word byte-count constants.
package loader_pkg;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler, used for both the header and instruction words.
// Word strobe is combinational on the 4th accepted byte; no backpressure of its own.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [1:0]  byte_cnt;
  logic [31:0] shreg;

  // Newest byte enters at the top, so after four shifts byte 0 sits in [7:0].
  assign word_dat = {byte_dat, shreg[31:8]};
  assign word_vld = byte_vld && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt <= 2'd0;
      shreg    <= 32'd0;
    end else if (byte_vld) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= word_dat;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: 4-byte LE word-count header, then N LE words written to imem, then core release.
// Write strobe lands one cycle after each word's 4th byte; accepts 1 byte/clk while HDR/LOAD.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_start,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [CNT_W:0] DEPTH_X = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;

  state_t            state, state_nxt;
  logic              accept;
  logic              word_vld;
  logic [31:0]       word_dat;
  logic [CNT_W:0]    hdr_ext;
  logic [ADDR_W:0]   hdr_n;
  logic [ADDR_W:0]   word_cnt;
  logic              wr;

  assign accept = in_valid && in_ready;

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .byte_vld (accept),
    .byte_dat (in_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  assign hdr_ext = {1'b0, word_dat[CNT_W-1:0]};
  assign wr      = (state == LOAD) && word_vld && (word_cnt != hdr_n);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      HDR: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (word_vld) begin
          if (hdr_ext == '0)          state_nxt = RUN;
          else if (hdr_ext > DEPTH_X) state_nxt = ERR;
          else                        state_nxt = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // Leave LOAD only after the final strobe so cpu_start trails it by a cycle.
        if (imem_we && (word_cnt == hdr_n)) state_nxt = RUN;
      end
      default: ;
    endcase
  end

  assign cpu_start    = (state == RUN);
  assign err          = (state == ERR);
  assign words_loaded = word_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= HDR;
      hdr_n      <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      state   <= state_nxt;
      imem_we <= 1'b0;
      // Only meaningful when the header leads to LOAD, where N <= DEPTH fits.
      if (state == HDR && word_vld) hdr_n <= word_dat[ADDR_W:0];
      if (wr) begin
        imem_we    <= 1'b1;
        imem_addr  <= word_cnt[ADDR_W-1:0];
        imem_wdata <= word_dat;
        word_cnt   <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader with ADDR_W=10.
module tb_program_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_start;
  logic              busy;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  program_loader #(.ADDR_W(ADDR_W), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_start    (cpu_start),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic [57:0] exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  wq[$];
  int   dup_we = 0;
  int   stray_we = 0;
  logic we_prev = 1'b0;
  vec_t tbl[14];
  logic [31:0] exp_words[DEPTH];

  // Write capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_t w;
      w.a = imem_addr;
      w.d = imem_wdata;
      wq.push_back(w);
      if (we_prev) dup_we++;
      if (!busy) stray_we++;
    end
    we_prev = imem_we;
  end

  function automatic logic [57:0] mk(input logic rdy, input logic we, input logic [ADDR_W-1:0] a,
                                     input logic [31:0] d, input logic cs, input logic bz,
                                     input logic er, input logic [ADDR_W:0] wl);
    return {rdy, we, a, d, cs, bz, er, wl};
  endfunction

  function automatic logic [57:0] outs();
    return {in_ready, imem_we, imem_addr, imem_wdata, cpu_start, busy, err, words_loaded};
  endfunction

  function automatic vec_t v(input logic vld, input logic [7:0] dat, input logic [57:0] e);
    vec_t r;
    r.vld = vld;
    r.dat = dat;
    r.exp = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    wq.delete();
  endtask

  // Holds in_valid until the byte transfers; leaves in_valid high for back-to-back use.
  task automatic send_byte(input logic [7:0] b);
    logic done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !done; i++) begin
      done = in_ready;
      step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end
  endtask

  initial begin
    logic [31:0] w;
    int mism;

    tbl[0]  = v(1, 8'h02, mk(1, 0, 0, 32'h0, 0, 1, 0, 0));
    tbl[1]  = v(1, 8'h00, mk(1, 0, 0, 32'h0, 0, 1, 0, 0));
    tbl[2]  = v(1, 8'h00, mk(1, 0, 0, 32'h0, 0, 1, 0, 0));
    tbl[3]  = v(1, 8'h00, mk(1, 0, 0, 32'h0, 0, 1, 0, 0));
    tbl[4]  = v(1, 8'h13, mk(1, 0, 0, 32'h0, 0, 1, 0, 0));
    tbl[5]  = v(1, 8'h00, mk(1, 0, 0, 32'h0, 0, 1, 0, 0));
    tbl[6]  = v(1, 8'h50, mk(1, 0, 0, 32'h0, 0, 1, 0, 0));
    tbl[7]  = v(1, 8'h00, mk(1, 1, 0, 32'h00500013, 0, 1, 0, 1));
    tbl[8]  = v(1, 8'h93, mk(1, 0, 0, 32'h00500013, 0, 1, 0, 1));
    tbl[9]  = v(1, 8'h00, mk(1, 0, 0, 32'h00500013, 0, 1, 0, 1));
    tbl[10] = v(1, 8'hA0, mk(1, 0, 0, 32'h00500013, 0, 1, 0, 1));
    tbl[11] = v(1, 8'h00, mk(1, 1, 1, 32'h00A00093, 0, 1, 0, 2));
    tbl[12] = v(0, 8'h00, mk(0, 0, 1, 32'h00A00093, 1, 0, 0, 2));
    tbl[13] = v(1, 8'hFF, mk(0, 0, 1, 32'h00A00093, 1, 0, 0, 2));

    // Two-word load, cycle by cycle.
    do_reset();
    chk("reset_state", 64'(outs()), 64'(mk(1, 0, 0, 32'h0, 0, 1, 0, 0)));
    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].dat;
      step();
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
    end
    in_valid = 1'b0;

    // Empty program releases the core straight from the header.
    do_reset();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("n0_cpu_start_pre", 64'(cpu_start), 64'd0);
    send_byte(8'h00);
    in_valid = 1'b0;
    chk("n0_cpu_start", 64'(cpu_start), 64'd1);
    chk("n0_err", 64'(err), 64'd0);
    chk("n0_in_ready", 64'(in_ready), 64'd0);
    step(); step();
    chk("n0_writes", 64'(wq.size()), 64'd0);

    // Oversized header: DEPTH+1.
    do_reset();
    send_byte(8'h01); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_cpu_start", 64'(cpu_start), 64'd0);
    chk("ovf_in_ready", 64'(in_ready), 64'd0);
    chk("ovf_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(i * 37);
      step();
    end
    in_valid = 1'b0;
    chk("ovf_writes", 64'(wq.size()), 64'd0);
    chk("ovf_err_sticky", 64'(err), 64'd1);

    // N=1 with in_valid toggling every cycle.
    do_reset();
    w = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = (i < 4) ? ((i == 0) ? 8'h01 : 8'h00) : w[8*(i-4) +: 8];
      step();
      in_valid = 1'b0;
      step();
    end
    step(); step();
    chk("tog_writes", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) begin
      chk("tog_addr", 64'(wq[0].a), 64'd0);
      chk("tog_data", 64'(wq[0].d), 64'hDEADBEEF);
    end
    chk("tog_words_loaded", 64'(words_loaded), 64'd1);
    chk("tog_cpu_start", 64'(cpu_start), 64'd1);

    // Reset mid-load, then a fresh N=1 load.
    do_reset();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    do_reset();
    chk("midrst_state", 64'({busy, in_ready, words_loaded}), 64'({2'b11, 11'd0}));
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    in_valid = 1'b0;
    step(); step();
    chk("midrst_writes", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) begin
      chk("midrst_addr", 64'(wq[0].a), 64'd0);
      chk("midrst_data", 64'(wq[0].d), 64'h11223344);
    end
    chk("midrst_words_loaded", 64'(words_loaded), 64'd1);
    chk("midrst_cpu_start", 64'(cpu_start), 64'd1);

    // Full-depth load with random payload.
    do_reset();
    for (int i = 0; i < DEPTH; i++) exp_words[i] = $urandom;
    send_byte(8'h00); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      w = exp_words[i];
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    end
    in_valid = 1'b0;
    step(); step(); step();
    chk("full_writes", 64'(wq.size()), 64'(DEPTH));
    mism = 0;
    for (int i = 0; i < wq.size() && i < DEPTH; i++)
      if (wq[i].a !== ADDR_W'(i) || wq[i].d !== exp_words[i]) mism++;
    chk("full_mismatches", 64'(mism), 64'd0);
    chk("full_words_loaded", 64'(words_loaded), 64'(DEPTH));
    chk("full_cpu_start", 64'(cpu_start), 64'd1);
    chk("full_err", 64'(err), 64'd0);

    chk("no_back_to_back_we", 64'(dup_we), 64'd0);
    chk("no_we_outside_load", 64'(stray_we), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader that sits directly upstream of the single-cycle core.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes those words sequentially into the instruction memory's write port.
- Releases the core by asserting cpu_start once the whole program is loaded. cpu_start drives the core's start input; the core is held while cpu_start=0.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
- CNT_W, 32, width of the word-count header field; fixed at 4 bytes.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid & in_ready at the clk edge.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write; byte address = imem_addr<<2.
- imem_wdata  out  32  instruction word.
- cpu_start  out  1  core release; 1 = core runs.
- busy  out  1  high in HDR and LOAD.
- err  out  1  sticky header error.
- words_loaded  out  ADDR_W+1  count of words written so far.

Behaviour:
- Reset (rst=0 at an edge):
  - state=HDR, byte_cnt=0, word_cnt=0, header=0.
  - Outputs: imem_we=0, imem_addr=0, imem_wdata=0, cpu_start=0, err=0, words_loaded=0.
  - in_ready=1 from the first cycle after reset.
- State HDR:
  - in_ready=1, busy=1.
  - Accept 4 bytes, LSB first, into header N.
  - On the 4th accepted byte:
    - N==0 -> RUN next cycle.
    - N>DEPTH -> ERR.
    - Otherwise -> LOAD.
- State LOAD:
  - in_ready=1, busy=1.
  - Bytes pack LSB first; byte_cnt wraps 3->0.
  - On the 4th byte of a word, the next cycle has: imem_we=1, imem_addr=word_cnt[ADDR_W-1:0], imem_wdata=assembled word.
  - word_cnt and words_loaded increment in the same edge that raises imem_we.
  - Bytes may keep transferring back-to-back during the write cycle. Peak throughput is 1 byte/clk with no bubbles.
  - After the write of word N-1: state=RUN, and cpu_start=1 in the cycle after the final imem_we pulse.
- State RUN:
  - in_ready=0, busy=0, cpu_start=1. Held until reset.
  - in_valid is ignored.
- State ERR:
  - in_ready=0, busy=0, err=1, cpu_start=0. Held until reset.
- imem_we is never high for more than one consecutive cycle per word, and never outside LOAD/final write.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Reset mid-load: returns to HDR immediately and counters clear. Already-written memory words are not cleared, and a subsequent load overwrites them.
- in_valid deasserted mid-word: partial bytes are retained indefinitely; no timeout.
- N==DEPTH is legal. The last address is DEPTH-1 and words_loaded reaches DEPTH (hence the ADDR_W+1 width).

Decomposition:
- Shared package loader_pkg:
  - State encodings HDR=2'd0, LOAD=2'd1, RUN=2'd2, ERR=2'd3.
  - HDR_BYTES=4, BYTES_PER_WORD=4.
- One natural sub-module, byte_packer:
  - 2-bit byte counter plus a 32-bit little-endian shift/insert register.
  - Emits word_valid for one cycle with the assembled word.
  - Reused for both the header and the instruction words.

Test Plan:
- Reset then bytes 02 00 00 00, 13 00 50 00, 93 00 A0 00 streamed back-to-back:
  - imem writes addr0=0x00500013, addr1=0x00A00093.
  - cpu_start=1 the cycle after the 2nd imem_we.
  - words_loaded=2, in_ready=0.
- Header 00 00 00 00 -> no imem_we pulses; cpu_start=1 the cycle after the 4th byte; err=0.
- Header with N=DEPTH+1 (ADDR_W=10: 01 04 00 00) -> err=1, cpu_start=0, in_ready=0; further bytes produce no imem_we.
- N=1 with in_valid toggling 1/0 every cycle -> a single write of the correct word. No spurious or duplicate imem_we.
- rst=0 asserted for one cycle after 6 bytes of an N=3 load, then a fresh N=1 load:
  - Only one write, at addr0.
  - words_loaded=1, cpu_start=1.
- N=DEPTH with random payload -> DEPTH writes at addresses 0..DEPTH-1, matching a scoreboard; words_loaded=DEPTH, cpu_start=1.
